// File: rtl/time_display_scan_pkg.sv
// Shared constants and helpers for the multiplexed HH:MM:SS display scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package time_display_scan_pkg;

  localparam int DIGITS           = 6;
  localparam int SCAN_DIV_DEFAULT = 1000;

  typedef logic [2:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a} patterns
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal split of a field value (inputs are at most 63)
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/time_display_scan_if.sv
// Time inputs and display-drive outputs of the scanner, bundled as one port.
// Latency: n/a (wires only).
// Backpressure: none; time source is sampled, display outputs are free-running.
interface time_display_scan_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [5:0] anode;
  logic [6:0] segments;
  logic       dp;
  logic       frame_sync;

  // Time source / display observer side
  modport master (
    output seconds, minutes, hours,
    input  anode, segments, dp, frame_sync
  );

  // Scanner side
  modport slave (
    input  seconds, minutes, hours,
    output anode, segments, dp, frame_sync
  );
endinterface

// File: rtl/time_display_scan_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern, with dash/blank overrides.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg7_decode
  import time_display_scan_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash wins over blank so an invalid field is always visible
  always_comb begin
    seg = SEG_DASH;
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed HH:MM:SS scanner with per-frame snapshot of the time inputs.
// Latency: drive outputs follow the digit index by 1 Clk; frame_sync 1 Clk after the capturing tick.
// Backpressure: none; free-running, inputs sampled only at frame boundaries.
module time_display_scan
  import time_display_scan_pkg::*;
#(
  parameter int SCAN_DIV   = SCAN_DIV_DEFAULT,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic                Clk,
  input  logic                reset,
  time_display_scan_if.slave  disp
);

  logic [15:0] prescale;
  logic        tick;
  digit_idx_t  digit_idx;
  logic        running;
  logic [5:0]  snap_sec;
  logic [5:0]  snap_min;
  logic [4:0]  snap_hr;
  logic        sec_bad, min_bad, hr_bad;
  logic [3:0]  code;
  logic        blank, dash;
  logic [6:0]  seg_next;
  logic [5:0]  anode_q;
  logic [6:0]  segments_q;
  logic        dp_q;
  logic        frame_sync_q;

  assign tick = (prescale == 16'(SCAN_DIV - 1));

  // Prescaler: one tick every SCAN_DIV cycles
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) prescale <= '0;
    else       prescale <= tick ? '0 : prescale + 16'd1;
  end

  // Digit sequencer; the time is captured only on the wrap to digit 0 so a frame is coherent
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      digit_idx    <= 3'd5;
      running      <= 1'b0;
      snap_sec     <= '0;
      snap_min     <= '0;
      snap_hr      <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      frame_sync_q <= tick && (digit_idx == 3'd5);
      if (tick) begin
        running <= 1'b1;
        if (digit_idx == 3'd5) begin
          digit_idx <= 3'd0;
          snap_sec  <= disp.seconds;
          snap_min  <= disp.minutes;
          snap_hr   <= disp.hours;
        end else begin
          digit_idx <= digit_idx + 3'd1;
        end
      end
    end
  end

  assign sec_bad = (snap_sec > 6'd59);
  assign min_bad = (snap_min > 6'd59);
  assign hr_bad  = (snap_hr  > 5'd23);

  // Pick the BCD digit and overrides for the slot being scanned
  always_comb begin
    code  = 4'd0;
    blank = 1'b0;
    dash  = 1'b0;
    case (digit_idx)
      3'd0: begin code = bcd_ones(snap_sec);         dash = sec_bad; end
      3'd1: begin code = bcd_tens(snap_sec);         dash = sec_bad; end
      3'd2: begin code = bcd_ones(snap_min);         dash = min_bad; end
      3'd3: begin code = bcd_tens(snap_min);         dash = min_bad; end
      3'd4: begin code = bcd_ones({1'b0, snap_hr});  dash = hr_bad;  end
      3'd5: begin
        code  = bcd_tens({1'b0, snap_hr});
        dash  = hr_bad;
        blank = BLANK_LEAD && !hr_bad && (snap_hr < 5'd10);
      end
      default: begin code = 4'd0; dash = 1'b1; end
    endcase
  end

  seg7_decode u_seg7_decode (
    .code  (code),
    .blank (blank),
    .dash  (dash),
    .seg   (seg_next)
  );

  // Registered drive; stays dark until the first tick so only one anode is ever low
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      anode_q    <= 6'h3F;
      segments_q <= 7'h7F;
      dp_q       <= 1'b1;
    end else if (running) begin
      anode_q    <= ~(6'd1 << digit_idx);
      segments_q <= seg_next;
      dp_q       <= !((digit_idx == 3'd2) || (digit_idx == 3'd4));
    end
  end

  assign disp.anode      = anode_q;
  assign disp.segments   = segments_q;
  assign disp.dp         = dp_q;
  assign disp.frame_sync = frame_sync_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with SCAN_DIV=4, leading blank on (dut_a) and off (dut_b).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_time_display_scan;

  logic Clk;
  logic reset;
  int   total;
  int   bad;

  logic [6:0] exp_a [6];
  logic [6:0] exp_b [6];
  logic [5:0] exp_an [6];
  logic       exp_dp [6];

  time_display_scan_if if_a ();
  time_display_scan_if if_b ();

  time_display_scan #(.SCAN_DIV(4), .BLANK_LEAD(1'b1)) dut_a (
    .Clk   (Clk),
    .reset (reset),
    .disp  (if_a)
  );

  time_display_scan #(.SCAN_DIV(4), .BLANK_LEAD(1'b0)) dut_b (
    .Clk   (Clk),
    .reset (reset),
    .disp  (if_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    if_a.hours = 5'(h); if_a.minutes = 6'(m); if_a.seconds = 6'(s);
    if_b.hours = 5'(h); if_b.minutes = 6'(m); if_b.seconds = 6'(s);
  endtask

  // Returns at the negedge where frame_sync is seen high
  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clk);
      if (if_a.frame_sync) seen = 1'b1;
    end
    chk("fs_seen", {7'd0, seen}, 8'd1);
  endtask

  // Release reset, then expect frame_sync on the 4th negedge with display still dark
  task automatic release_reset();
    @(negedge Clk);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clk);
      chk("fs_before_tick", {7'd0, if_a.frame_sync}, 8'd0);
    end
    @(negedge Clk);
    chk("fs_first", {7'd0, if_a.frame_sync}, 8'd1);
    chk("anode_dark_at_fs", {2'd0, if_a.anode}, 8'h3F);
  endtask

  // Starts at the frame_sync negedge; digit k is sampled mid-slot
  task automatic read_frame(input int mid_sec);
    @(negedge Clk);
    chk("fs_one_cycle", {7'd0, if_a.frame_sync}, 8'd0);
    @(negedge Clk);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("anode_d%0d", k), {2'd0, if_a.anode}, {2'd0, exp_an[k]});
      chk($sformatf("seg_a_d%0d", k), {1'b0, if_a.segments}, {1'b0, exp_a[k]});
      chk($sformatf("seg_b_d%0d", k), {1'b0, if_b.segments}, {1'b0, exp_b[k]});
      chk($sformatf("dp_d%0d", k), {7'd0, if_a.dp}, {7'd0, exp_dp[k]});
      if (k == 2 && mid_sec >= 0) begin
        if_a.seconds = 6'(mid_sec);
        if_b.seconds = 6'(mid_sec);
      end
      if (k < 5) repeat (4) @(negedge Clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_an = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    exp_dp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1;
    set_time(23, 59, 58);
    repeat (3) @(negedge Clk);
    chk("rst_anode", {2'd0, if_a.anode}, 8'h3F);
    chk("rst_seg", {1'b0, if_a.segments}, 8'h7F);
    chk("rst_dp", {7'd0, if_a.dp}, 8'd1);
    chk("rst_fs", {7'd0, if_a.frame_sync}, 8'd0);

    // 23:59:58
    release_reset();
    exp_a = '{7'h00, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
    exp_b = exp_a;
    read_frame(-1);

    // 05:07:09: leading hours digit blanked only when enabled
    set_time(5, 7, 9);
    wait_fs();
    exp_a = '{7'h10, 7'h40, 7'h78, 7'h40, 7'h12, 7'h7F};
    exp_b = '{7'h10, 7'h40, 7'h78, 7'h40, 7'h12, 7'h40};
    read_frame(-1);

    // 12:34:56, seconds change to 57 during digit 2
    set_time(12, 34, 56);
    wait_fs();
    exp_a = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    exp_b = exp_a;
    read_frame(57);
    wait_fs();
    exp_a[0] = 7'h78;
    exp_b[0] = 7'h78;
    read_frame(-1);

    // Out-of-range seconds/minutes show dashes; hours unaffected
    set_time(12, 61, 60);
    wait_fs();
    exp_a = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h24, 7'h79};
    exp_b = exp_a;
    read_frame(-1);

    // Reset during digit 3 takes effect without a clock edge
    wait_fs();
    repeat (14) @(negedge Clk);
    chk("pre_rst_anode_d3", {2'd0, if_a.anode}, 8'h37);
    reset = 1'b1;
    #1;
    chk("async_rst_anode", {2'd0, if_a.anode}, 8'h3F);
    chk("async_rst_seg", {1'b0, if_a.segments}, 8'h7F);
    chk("async_rst_dp", {7'd0, if_a.dp}, 8'd1);
    chk("async_rst_fs", {7'd0, if_a.frame_sync}, 8'd0);
    set_time(5, 7, 9);
    repeat (2) @(negedge Clk);
    release_reset();
    exp_a = '{7'h10, 7'h40, 7'h78, 7'h40, 7'h12, 7'h7F};
    exp_b = '{7'h10, 7'h40, 7'h78, 7'h40, 7'h12, 7'h40};
    read_frame(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
